// File: rtl/game_seq_ctrl.sv
// game_seq_ctrl: game sequencing controller.
// Synchronizes the start switch and the action button, debounces the button,
// and runs the IDLE/PLAY/PAUSE/OVER state machine. In PLAY it divides frame
// pulses into game-update steps, keeps a saturating four-digit BCD score, and
// tracks lives with a post-hit immunity window.
//
// Ports:
//   I_clk          system clock, rising edge
//   I_rst          asynchronous active-high reset
//   start_game     raw level switch (asynchronous)
//   BTNX4          raw action push-button (asynchronous, bouncy)
//   I_frame_start  one-cycle pulse at the start of each video frame
//   I_hit          one-cycle collision pulse
//   O_state        00 IDLE, 01 PLAY, 10 PAUSE, 11 OVER
//   O_step         one-cycle game-update strobe
//   O_action       one-cycle debounced button-press strobe (PLAY only)
//   O_score        four BCD digits, [15:12] most significant
//   O_lives        remaining lives
//   O_game_over    high while O_state is OVER
module game_seq_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned FRAMES_PER_STEP = 4,
    parameter int unsigned MAX_LIVES       = 3,
    parameter int unsigned IMMUNE_FRAMES   = 30
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic        start_game,
    input  logic        BTNX4,
    input  logic        I_frame_start,
    input  logic        I_hit,
    output logic [1:0]  O_state,
    output logic        O_step,
    output logic        O_action,
    output logic [15:0] O_score,
    output logic [1:0]  O_lives,
    output logic        O_game_over
);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StPlay  = 2'b01,
        StPause = 2'b10,
        StOver  = 2'b11
    } state_e;

    localparam int unsigned DebW = $clog2(DEBOUNCE_CYCLES + 1);

    logic            s_meta_q, ss_q;
    logic            b_meta_q, bs_q;
    logic            btn_q;
    logic [DebW-1:0] deb_cnt_q;

    state_e          state_q;
    logic [7:0]      frame_cnt_q;
    logic [7:0]      imm_q;
    logic            step_q;
    logic            action_q;
    logic [15:0]     score_q;
    logic [1:0]      lives_q;
    logic            game_over_q;

    logic            btn_rise;
    logic            in_play;
    logic            frame_play;
    logic            wrap;
    logic            hit_ok;
    logic            fatal;

    // Saturating BCD increment: 9999 stays 9999.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        if (v == 16'h9999) begin
            r = v;
        end
        return r;
    endfunction

    // Accepted level flips from 0 to 1 on this edge.
    always_comb begin
        btn_rise   = !btn_q && bs_q && (deb_cnt_q == DebW'(DEBOUNCE_CYCLES - 1));
        in_play    = (state_q == StPlay);
        frame_play = in_play && I_frame_start;
        wrap       = frame_play && (frame_cnt_q == 8'(FRAMES_PER_STEP - 1));
        hit_ok     = in_play && I_hit && (imm_q == 8'd0);
        fatal      = hit_ok && (lives_q == 2'd1);
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            s_meta_q  <= 1'b0;
            ss_q      <= 1'b0;
            b_meta_q  <= 1'b0;
            bs_q      <= 1'b0;
            btn_q     <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            s_meta_q <= start_game;
            ss_q     <= s_meta_q;
            b_meta_q <= BTNX4;
            bs_q     <= b_meta_q;
            // Any cycle where bs agrees with the accepted level restarts the count.
            if (bs_q != btn_q) begin
                if (deb_cnt_q == DebW'(DEBOUNCE_CYCLES - 1)) begin
                    btn_q     <= bs_q;
                    deb_cnt_q <= '0;
                end else begin
                    deb_cnt_q <= deb_cnt_q + 1'b1;
                end
            end else begin
                deb_cnt_q <= '0;
            end
        end
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q     <= StIdle;
            frame_cnt_q <= 8'd0;
            imm_q       <= 8'd0;
            step_q      <= 1'b0;
            action_q    <= 1'b0;
            score_q     <= 16'h0000;
            lives_q     <= 2'd0;
            game_over_q <= 1'b0;
        end else begin
            step_q   <= 1'b0;
            action_q <= btn_rise && in_play;
            case (state_q)
                StIdle: begin
                    if (ss_q) begin
                        state_q     <= StPlay;
                        score_q     <= 16'h0000;
                        lives_q     <= 2'(MAX_LIVES);
                        frame_cnt_q <= 8'd0;
                        imm_q       <= 8'd0;
                    end
                end
                StPlay: begin
                    if (frame_play) begin
                        frame_cnt_q <= wrap ? 8'd0 : frame_cnt_q + 8'd1;
                    end
                    if (hit_ok) begin
                        imm_q   <= 8'(IMMUNE_FRAMES);
                        lives_q <= lives_q - 2'd1;
                    end else if (frame_play && (imm_q != 8'd0)) begin
                        imm_q <= imm_q - 8'd1;
                    end
                    // A game-ending hit suppresses a coincident step.
                    if (wrap && !fatal) begin
                        step_q  <= 1'b1;
                        score_q <= bcd_inc(score_q);
                    end
                    if (fatal) begin
                        state_q     <= StOver;
                        game_over_q <= 1'b1;
                    end else if (!ss_q) begin
                        state_q <= StPause;
                    end
                end
                StPause: begin
                    if (ss_q) begin
                        state_q <= StPlay;
                    end
                end
                StOver: begin
                    if (!ss_q) begin
                        state_q     <= StIdle;
                        game_over_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign O_state     = state_q;
    assign O_step      = step_q;
    assign O_action    = action_q;
    assign O_score     = score_q;
    assign O_lives     = lives_q;
    assign O_game_over = game_over_q;

endmodule

// File: tb/tb_game_seq_ctrl.sv
// Directed bench for game_seq_ctrl with small parameters
// (DEBOUNCE_CYCLES=4, FRAMES_PER_STEP=2, MAX_LIVES=3, IMMUNE_FRAMES=2).
module tb_game_seq_ctrl;

    logic        I_clk;
    logic        I_rst;
    logic        start_game;
    logic        BTNX4;
    logic        I_frame_start;
    logic        I_hit;
    logic [1:0]  O_state;
    logic        O_step;
    logic        O_action;
    logic [15:0] O_score;
    logic [1:0]  O_lives;
    logic        O_game_over;

    int total;
    int bad;
    int step_cnt;
    int act_cnt;

    game_seq_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .FRAMES_PER_STEP(2),
        .MAX_LIVES      (3),
        .IMMUNE_FRAMES  (2)
    ) dut (
        .I_clk        (I_clk),
        .I_rst        (I_rst),
        .start_game   (start_game),
        .BTNX4        (BTNX4),
        .I_frame_start(I_frame_start),
        .I_hit        (I_hit),
        .O_state      (O_state),
        .O_step       (O_step),
        .O_action     (O_action),
        .O_score      (O_score),
        .O_lives      (O_lives),
        .O_game_over  (O_game_over)
    );

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    // Advance n cycles, sampling strobes 1 time unit after each rising edge.
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge I_clk);
            #1;
            if (O_step === 1'b1) step_cnt++;
            if (O_action === 1'b1) act_cnt++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic frame();
        I_frame_start = 1'b1;
        cyc(1);
        I_frame_start = 1'b0;
        cyc(1);
    endtask

    task automatic hit();
        I_hit = 1'b1;
        cyc(1);
        I_hit = 1'b0;
        cyc(1);
    endtask

    initial begin
        total = 0;
        bad = 0;
        step_cnt = 0;
        act_cnt = 0;
        I_rst = 1'b1;
        start_game = 1'b0;
        BTNX4 = 1'b0;
        I_frame_start = 1'b0;
        I_hit = 1'b0;
        #1;
        chk("rst_state", 32'(O_state), 32'd0);
        chk("rst_score", 32'(O_score), 32'h0000);
        chk("rst_lives", 32'(O_lives), 32'd0);
        chk("rst_over", 32'(O_game_over), 32'd0);
        cyc(2);
        I_rst = 1'b0;
        cyc(2);

        // Start: PLAY on the third edge.
        start_game = 1'b1;
        cyc(2);
        chk("start_edge2", 32'(O_state), 32'd0);
        cyc(1);
        chk("start_edge3", 32'(O_state), 32'd1);
        chk("start_lives", 32'(O_lives), 32'd3);
        chk("start_score", 32'(O_score), 32'h0000);

        // 6 frames -> 3 steps.
        step_cnt = 0;
        for (int i = 0; i < 6; i++) frame();
        chk("six_frames_steps", 32'(step_cnt), 32'd3);
        chk("six_frames_score", 32'(O_score), 32'h0003);

        // Bouncy press then long hold -> one action; release -> none.
        act_cnt = 0;
        BTNX4 = 1'b1;
        cyc(1);
        BTNX4 = 1'b0;
        cyc(1);
        BTNX4 = 1'b1;
        cyc(8);
        chk("bounce_action", 32'(act_cnt), 32'd1);
        cyc(100);
        chk("hold_action", 32'(act_cnt), 32'd1);
        BTNX4 = 1'b0;
        cyc(10);
        chk("release_action", 32'(act_cnt), 32'd1);

        // Two more steps -> 0005, then pause.
        for (int i = 0; i < 4; i++) frame();
        chk("score5", 32'(O_score), 32'h0005);
        start_game = 1'b0;
        cyc(3);
        chk("pause_state", 32'(O_state), 32'd2);
        act_cnt = 0;
        step_cnt = 0;
        BTNX4 = 1'b1;
        cyc(10);
        BTNX4 = 1'b0;
        cyc(10);
        chk("pause_action", 32'(act_cnt), 32'd0);
        for (int i = 0; i < 4; i++) frame();
        hit();
        chk("pause_steps", 32'(step_cnt), 32'd0);
        chk("pause_lives", 32'(O_lives), 32'd3);
        start_game = 1'b1;
        cyc(3);
        chk("resume_state", 32'(O_state), 32'd1);
        chk("resume_score", 32'(O_score), 32'h0005);

        // Hits and immunity.
        hit();
        chk("hit1_lives", 32'(O_lives), 32'd2);
        frame();
        hit();
        chk("hit2_ignored", 32'(O_lives), 32'd2);
        frame();
        frame();
        hit();
        chk("hit3_lives", 32'(O_lives), 32'd1);
        chk("hit3_score", 32'(O_score), 32'h0006);
        frame();
        frame();
        chk("prefatal_score", 32'(O_score), 32'h0007);

        // Step and fatal hit together: hit wins.
        step_cnt = 0;
        I_hit = 1'b1;
        I_frame_start = 1'b1;
        cyc(1);
        I_hit = 1'b0;
        I_frame_start = 1'b0;
        chk("fatal_state", 32'(O_state), 32'd3);
        chk("fatal_over", 32'(O_game_over), 32'd1);
        chk("fatal_lives", 32'(O_lives), 32'd0);
        chk("fatal_score", 32'(O_score), 32'h0007);
        cyc(2);
        chk("fatal_no_step", 32'(step_cnt), 32'd0);
        start_game = 1'b0;
        cyc(2);
        chk("over_hold", 32'(O_state), 32'd3);
        cyc(1);
        chk("over_to_idle", 32'(O_state), 32'd0);
        chk("idle_over_flag", 32'(O_game_over), 32'd0);

        // Restart and run the score up to its BCD boundaries.
        start_game = 1'b1;
        cyc(3);
        chk("restart_state", 32'(O_state), 32'd1);
        chk("restart_score", 32'(O_score), 32'h0000);
        chk("restart_lives", 32'(O_lives), 32'd3);
        I_frame_start = 1'b1;
        cyc(1998);
        chk("score_0999", 32'(O_score), 32'h0999);
        cyc(2);
        chk("score_1000", 32'(O_score), 32'h1000);
        cyc(17998);
        chk("score_9999", 32'(O_score), 32'h9999);
        cyc(2);
        chk("score_sat", 32'(O_score), 32'h9999);
        I_frame_start = 1'b0;
        cyc(1);

        // Asynchronous reset mid-PLAY.
        #2;
        I_rst = 1'b1;
        start_game = 1'b0;
        #1;
        chk("arst_state", 32'(O_state), 32'd0);
        chk("arst_step", 32'(O_step), 32'd0);
        chk("arst_action", 32'(O_action), 32'd0);
        chk("arst_score", 32'(O_score), 32'h0000);
        chk("arst_lives", 32'(O_lives), 32'd0);
        chk("arst_over", 32'(O_game_over), 32'd0);
        cyc(2);
        I_rst = 1'b0;
        cyc(5);
        chk("post_rst_idle", 32'(O_state), 32'd0);
        start_game = 1'b1;
        cyc(3);
        chk("post_rst_play", 32'(O_state), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
